// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM encoding and helpers shared by the SPI flash emulator
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST = 8'h0B;
  localparam logic [7:0] OP_RDID = 8'h9F;

  localparam int ADDR_CNT_W  = 6;
  localparam int DUMMY_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_ID,
    S_IGNORE
  } state_e;

  // JEDEC ID byte for a given byte index; past the third byte the device returns zeros
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    return idx == 2'd0 ? id[23:16] : idx == 2'd1 ? id[15:8] : idx == 2'd2 ? id[7:0] : 8'h00;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchroniser with an edge (toggle) output on the synchronised value
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic tgl
);

  logic meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;

  // shift the raw input through the metastability chain and keep one cycle of history
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // chain flops load the idle level of the pin while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q   = sync_q;
  assign tgl = sync_q ^ prev_q;

endmodule

// File: rtl/spi_flash_emu.sv
// spi_flash_emu: SPI (mode 0) flash read emulator with JEDEC ID and one-byte prefetch
module spi_flash_emu
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_BYTES   = 3,
  parameter int          DEPTH_LOG2   = 16,
  parameter int          DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4016
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  spi_csb,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  err
);

  localparam logic [ADDR_CNT_W-1:0]  ADDR_LAST  = ADDR_CNT_W'(8 * ADDR_BYTES - 1);
  localparam logic [DUMMY_CNT_W-1:0] DUMMY_LAST = DUMMY_CNT_W'(DUMMY_CYCLES - 1);
  localparam logic                   HAS_DUMMY  = DUMMY_CYCLES != 0;

  logic [1:0] rst_sync_q;
  logic       rst_n;
  logic       csb_s, csb_tgl, sck_s, sck_tgl, mosi_s, mosi_tgl_unused;
  logic       csb_fall, sck_rise, sck_fall;
  logic [7:0] opcode;

  state_e                  state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [6:0]              cmd_q, cmd_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [ADDR_CNT_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [DUMMY_CNT_W-1:0]  dummy_cnt_q, dummy_cnt_d;
  logic                    fast_q, fast_d;
  logic [7:0]              sh_out_q, sh_out_d;
  logic [1:0]              id_cnt_q, id_cnt_d;
  logic [7:0]              pf_q, pf_d;
  logic                    pf_vld_q, pf_vld_d;
  logic                    mem_req_q, mem_req_d;
  logic [DEPTH_LOG2-1:0]   mem_addr_q, mem_addr_d;
  logic                    err_q, err_d;

  // reset asserts immediately but releases only after two clean clock edges
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) rst_sync_q <= 2'b00;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  spi_sync #(.RST_VAL(1'b1)) u_sync_csb (
    .clk(clock), .rst_n(rst_n), .d(spi_csb), .q(csb_s), .tgl(csb_tgl)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clock), .rst_n(rst_n), .d(spi_sck), .q(sck_s), .tgl(sck_tgl)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clock), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s), .tgl(mosi_tgl_unused)
  );

  assign csb_fall = csb_tgl & ~csb_s;
  assign sck_rise = sck_tgl & sck_s;
  assign sck_fall = sck_tgl & ~sck_s;
  assign opcode   = {cmd_q, mosi_s};

  // protocol FSM: shift in command/address on SCK rise, shift out data on SCK fall
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    addr_cnt_d  = addr_cnt_q;
    dummy_cnt_d = dummy_cnt_q;
    fast_d      = fast_q;
    sh_out_d    = sh_out_q;
    id_cnt_d    = id_cnt_q;
    pf_d        = pf_q;
    pf_vld_d    = pf_vld_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    err_d       = err_q;
    // a read return arriving once CSB is high belongs to a finished transaction and is dropped
    if (mem_ack && !csb_s) begin
      pf_d     = mem_rdata;
      pf_vld_d = 1'b1;
    end
    if (csb_s) begin
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      addr_cnt_d  = '0;
      dummy_cnt_d = '0;
      id_cnt_d    = '0;
      sh_out_d    = '0;
      pf_vld_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = csb_fall ? S_CMD : S_IDLE;
        S_CMD: if (sck_rise) begin
          cmd_d     = opcode[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            fast_d  = opcode == OP_FAST;
            state_d = (opcode == OP_READ || opcode == OP_FAST) ? S_ADDR :
                      opcode == OP_RDID ? S_ID : S_IGNORE;
          end
        end
        S_ADDR: if (sck_rise) begin
          addr_d     = {addr_q[DEPTH_LOG2-2:0], mosi_s};
          addr_cnt_d = addr_cnt_q + ADDR_CNT_W'(1);
          if (addr_cnt_q == ADDR_LAST) begin
            state_d    = fast_q && HAS_DUMMY ? S_DUMMY : S_DATA;
            mem_req_d  = !(fast_q && HAS_DUMMY);
            mem_addr_d = addr_d;
          end
        end
        S_DUMMY: if (sck_rise) begin
          dummy_cnt_d = dummy_cnt_q + DUMMY_CNT_W'(1);
          if (dummy_cnt_q == DUMMY_LAST) begin
            state_d    = S_DATA;
            mem_req_d  = 1'b1;
            mem_addr_d = addr_q;
          end
        end
        S_DATA: if (sck_fall) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q != 3'd0) sh_out_d = {sh_out_q[6:0], 1'b0};
          else if (pf_vld_q) begin
            sh_out_d   = pf_q;
            pf_vld_d   = 1'b0;
            addr_d     = addr_q + DEPTH_LOG2'(1);
            mem_addr_d = addr_q + DEPTH_LOG2'(1);
            mem_req_d  = 1'b1;
          end else begin
            // underrun: the fetch is still outstanding and will serve the next byte
            sh_out_d = 8'hFF;
            err_d    = 1'b1;
          end
        end
        S_ID: if (sck_fall) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          sh_out_d  = bit_cnt_q == 3'd0 ? id_byte(JEDEC_ID, id_cnt_q) : {sh_out_q[6:0], 1'b0};
          id_cnt_d  = bit_cnt_q == 3'd0 && id_cnt_q != 2'd3 ? id_cnt_q + 2'd1 : id_cnt_q;
        end
        default: ;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      addr_cnt_q  <= '0;
      dummy_cnt_q <= '0;
      fast_q      <= 1'b0;
      sh_out_q    <= '0;
      id_cnt_q    <= '0;
      pf_q        <= '0;
      pf_vld_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      addr_cnt_q  <= addr_cnt_d;
      dummy_cnt_q <= dummy_cnt_d;
      fast_q      <= fast_d;
      sh_out_q    <= sh_out_d;
      id_cnt_q    <= id_cnt_d;
      pf_q        <= pf_d;
      pf_vld_q    <= pf_vld_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      err_q       <= err_d;
    end
  end

  assign spi_miso_oe = (state_q == S_DATA || state_q == S_ID) && !csb_s;
  assign spi_miso    = spi_miso_oe & sh_out_q[7];
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = state_q != S_IDLE;
  assign err         = err_q;

endmodule

// File: tb/tb_spi_flash_emu.sv
// tb_spi_flash_emu: directed SPI master with a byte scoreboard and a simple memory responder
module tb_spi_flash_emu;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        spi_csb = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        spi_miso, spi_miso_oe, mem_req, busy, err;
  logic [15:0] mem_addr;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int oe_seen = 0;
  int ack_delay = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] req_q[$];

  spi_flash_emu dut (
    .clock(clock), .resetb(resetb), .spi_csb(spi_csb), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // memory holds 0xA0 + addr (mod 256); acknowledges after ack_delay clocks
  initial forever begin
    @(negedge clock);
    mem_ack = 1'b0;
    if (mem_req) begin
      req_cnt++;
      req_q.push_back(mem_addr);
      mem_rdata = 8'hA0 + mem_addr[7:0];
      repeat (ack_delay) @(negedge clock);
      mem_ack = 1'b1;
    end
  end

  initial forever begin
    @(negedge clock);
    if (spi_miso_oe) oe_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0 bit cycle at SCK = clock/8: drive MOSI with SCK low, sample MISO just before the rise
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_sck = 1'b0;
      spi_mosi = tx[7-i];
      repeat (4) @(negedge clock);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (4) @(negedge clock);
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] rx;
    xfer(tx, 8, rx);
  endtask

  task automatic drain(input string tag);
    logic [7:0] rx;
    while (exp_q.size() != 0) begin
      xfer(8'h00, 8, rx);
      check(tag, rx, exp_q.pop_front());
    end
  endtask

  task automatic cs_start();
    spi_csb = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic cs_end();
    spi_sck = 1'b0;
    spi_csb = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  initial begin
    logic [7:0] rx;
    int r0, o0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_miso", spi_miso, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    resetb = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_busy", busy, 0);

    exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h16); exp_q.push_back(8'h00);
    cs_start();
    send(8'h9F);
    check("id_oe", spi_miso_oe, 1);
    check("id_busy", busy, 1);
    drain("id_byte");
    cs_end();
    check("id_done_busy", busy, 0);

    r0 = req_cnt;
    req_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hB0 + 8'(i));
    cs_start();
    send(8'h03); send(8'h00); send(8'h00); send(8'h10);
    drain("read_byte");
    cs_end();
    // one fetch per byte read plus the prefetch of 0x14 taken at the fourth byte
    check("read_req_cnt", req_cnt - r0, 5);
    for (int i = 0; i < 4; i++) check("read_req_addr", req_q[i], 16'h0010 + 16'(i));
    check("read_err", err, 0);

    req_q.delete();
    exp_q.push_back(8'h9F); exp_q.push_back(8'hA0);
    cs_start();
    send(8'h0B); send(8'h00); send(8'hFF); send(8'hFF);
    send(8'h00);
    drain("fast_byte");
    cs_end();
    check("fast_req0", req_q[0], 16'hFFFF);
    check("fast_req1", req_q[1], 16'h0000);
    check("fast_err", err, 0);

    r0 = req_cnt;
    cs_start();
    send(8'h03); send(8'h00);
    xfer(8'h00, 4, rx);
    spi_csb = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_busy", busy, 0);
    spi_sck = 1'b0;
    repeat (6) @(negedge clock);
    check("abort_no_req", req_cnt - r0, 0);
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h16);
    cs_start();
    send(8'h9F);
    drain("abort_id_byte");
    cs_end();

    r0 = req_cnt;
    o0 = oe_seen;
    cs_start();
    send(8'h5A);
    xfer(8'h00, 8, rx);
    check("ign_miso", rx, 0);
    check("ign_busy", busy, 1);
    send(8'h00);
    cs_end();
    check("ign_oe", oe_seen - o0, 0);
    check("ign_req", req_cnt - r0, 0);

    ack_delay = 20;
    exp_q.push_back(8'hFF);
    cs_start();
    send(8'h03); send(8'h00); send(8'h00); send(8'h20);
    drain("under_byte");
    check("under_err", err, 1);
    cs_end();
    ack_delay = 0;
    check("under_err_sticky", err, 1);
    check("under_busy", busy, 0);

    resetb = 1'b0;
    repeat (2) @(negedge clock);
    check("rerst_err", err, 0);
    resetb = 1'b1;
    repeat (4) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_emu.md
SPI_FLASH_EMU -- requirements
Module: spi_flash_emu

Interface
REQ-001 Parameter ADDR_BYTES, 3, number of address bytes after a read opcode (3 or 4).
REQ-002 Parameter DEPTH_LOG2, 16, memory depth in address bits; the address wraps modulo 2^DEPTH_LOG2.
REQ-003 Parameter DUMMY_CYCLES, 8, SCK cycles between address and data for fast read 0x0B.
REQ-004 Parameter JEDEC_ID, 24'hEF4016, three bytes returned MSB-first by opcode 0x9F.
REQ-005 Port clock, input, 1, single system clock; all logic is on its rising edge.
REQ-006 Port resetb, input, 1, asynchronous active-low reset.
REQ-007 Port spi_csb, input, 1, chip select, active low.
REQ-008 Port spi_sck, input, 1, SPI clock (mode 0), oversampled by clock.
REQ-009 Port spi_mosi, input, 1, serial data in (io0).
REQ-010 Port spi_miso, output, 1, serial data out (io1).
REQ-011 Port spi_miso_oe, output, 1, output enable for spi_miso; the pad is tri-stated when this is 0.
REQ-012 Ports mem_addr output [DEPTH_LOG2-1:0], mem_req output 1, mem_ack input 1, mem_rdata input 8: byte read port.
REQ-013 Ports busy output 1 (transaction active) and err output 1 (sticky underrun flag).

Function
REQ-014 spi_csb, spi_sck and spi_mosi SHALL each pass through a 2-flop synchroniser; SCK edges are detected on the synchronised value; the supported SCK frequency is at most clock/8.
REQ-015 The module SHALL sample MOSI on SCK rising edges and update MISO on SCK falling edges, MSB first.
REQ-016 The state machine SHALL have states IDLE, CMD, ADDR, DUMMY, DATA, ID and IGNORE.
REQ-017 A falling edge of synchronised CSB SHALL move IDLE->CMD; after 8 bits the FSM SHALL branch: 0x03->ADDR, 0x0B->ADDR, 0x9F->ID, any other opcode->IGNORE.
REQ-018 ADDR SHALL shift in 8*ADDR_BYTES bits and keep the low DEPTH_LOG2 bits; it then goes to DUMMY for 0x0B, otherwise to DATA.
REQ-019 DUMMY SHALL count exactly DUMMY_CYCLES SCK rising edges, then go to DATA.
REQ-020 On the last address or dummy edge, mem_req SHALL pulse for one clock with mem_addr set to the address.
REQ-021 mem_rdata SHALL be captured on the cycle mem_ack is high into a one-byte prefetch buffer.
REQ-022 On each byte boundary in DATA, the buffer SHALL move to the shift register, the address SHALL increment modulo 2^DEPTH_LOG2, and the next mem_req SHALL be issued.
REQ-023 If the buffer is empty at a byte boundary, the module SHALL shift out 0xFF and set err; err stays set until reset.
REQ-024 ID SHALL shift out JEDEC_ID, followed by 0x00 for any further SCK cycles.
REQ-025 spi_miso_oe SHALL be 1 only in DATA and ID while CSB is low; in all other states spi_miso is 0 and the output is disabled.
REQ-026 CSB rising at any point SHALL return the FSM to IDLE within 3 clocks and clear the bit counters and the buffer-valid flag; a mem_ack still outstanding is absorbed and discarded.
REQ-027 A mem_ack that coincides with a CSB rise SHALL NOT set err or load the shift register.
REQ-028 busy SHALL equal (state != IDLE).

Reset
REQ-029 When resetb is low: state is IDLE, spi_miso=0, spi_miso_oe=0, mem_req=0, mem_addr=0, busy=0, err=0, synchronisers are loaded with CSB=1, SCK=0 and MOSI=0, and the buffer is invalid.
REQ-030 Reset deassertion SHALL be synchronised with a 2-flop reset synchroniser before it reaches the FSM.

Structure
REQ-031 Opcode constants (0x03, 0x0B, 0x9F) and the state encoding SHALL live in shared package spi_flash_pkg.
REQ-032 A single sub-module spi_sync (2-flop synchroniser with an edge-detect output) SHALL be instantiated once per SPI input.

Verification
REQ-033 Opcode 0x9F followed by 32 SCK cycles -> MISO returns EF 40 16 00.
REQ-034 Opcode 0x03, address 0x000010, 4 bytes read, memory holding byte value 0xA0+addr -> A0+0x10..A0+0x13, one mem_req per byte, err=0.
REQ-035 Opcode 0x0B, address 0x00FFFF, 8 dummy cycles, 2 bytes read -> bytes from 0xFFFF then 0x0000 (wrap).
REQ-036 CSB raised after 12 address bits -> no mem_req, busy=0 within 3 clocks; a following 0x9F transaction works normally.
REQ-037 mem_ack held off for 20 clocks at SCK = clock/8 -> first data byte 0xFF and err=1; err stays 1 after CSB rises.
REQ-038 Opcode 0x5A -> spi_miso_oe stays 0 for the whole transaction and mem_req never fires.
